pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 The block SHALL have parameter STEP, default 4, meaning the sequential PC increment in bytes.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port stall, input, 1 bit: hold the PC and suppress fetch.
REQ-007 The block SHALL have ports redirect_valid (input, 1) and redirect_pc (input, XLEN): a branch or jump target.
REQ-008 The block SHALL have ports trap_valid (input, 1) and trap_vector (input, XLEN): an exception or interrupt target.
REQ-009 The block SHALL have ports halt_req (input, 1) and resume (input, 1): debug halt control.
REQ-010 The block SHALL have port fetch_ready, input, 1 bit: the instruction memory accepts the request.
REQ-011 The block SHALL have ports fetch_valid (output, 1) and fetch_pc (output, XLEN): the fetch request.
REQ-012 The block SHALL have port pc_plus, output, XLEN: fetch_pc+STEP, combinational, for the link register.
REQ-013 The block SHALL have port halted, output, 1 bit: high while in the HALT state.
REQ-014 The block SHALL have port misalign_err, output, 1 bit: a one-cycle pulse on a rejected target.

Function
REQ-015 The block SHALL implement an FSM with states BOOT, RUN and HALT.
REQ-016 The FSM SHALL be in BOOT after reset, with fetch_valid=0, and SHALL move to RUN unconditionally on the next clock edge.
REQ-017 In RUN, fetch_valid SHALL equal !stall.
REQ-018 In BOOT and HALT, fetch_valid SHALL be 0.
REQ-019 The next-PC priority SHALL be: trap_valid, then redirect_valid, then stall (hold), then handshake (fetch_pc+STEP), then hold.
REQ-020 A trap or redirect SHALL load the PC on the next edge even when stall=1 or no handshake occurs; the current request is abandoned and no handshake is counted.
REQ-021 Sequential increment SHALL occur only on fetch_valid&&fetch_ready.
REQ-022 fetch_pc SHALL stay stable while fetch_valid=1 and fetch_ready=0, unless a trap or redirect occurs.
REQ-023 PC arithmetic SHALL be modulo 2^XLEN: PC 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
REQ-024 In RUN, halt_req=1 SHALL move the FSM to HALT on the next edge; a same-cycle trap, redirect or handshake SHALL still update the PC in that cycle.
REQ-025 In HALT, the PC SHALL hold, with one exception: trap_valid loads trap_vector and the FSM stays in HALT.
REQ-026 In HALT, resume=1 SHALL return the FSM to RUN on the next edge; if halt_req and resume are both high, HALT SHALL persist.
REQ-027 In BOOT, trap, redirect and halt inputs SHALL be ignored.

Reset
REQ-028 On rst_n=0, the block SHALL asynchronously set fetch_pc=RESET_VECTOR, state=BOOT, fetch_valid=0, halted=0 and misalign_err=0.
REQ-029 Reset asserted mid-stall, mid-HALT or with a pending handshake SHALL discard all of it; after release, the first request SHALL be RESET_VECTOR at the second edge.

Configuration
REQ-030 With macro PC_MISALIGN_CHECK_EN defined, a trap or redirect target with bits [1:0]!=0 SHALL be rejected: the PC holds, and misalign_err pulses for one cycle in the cycle after the rejected request.
REQ-031 With PC_MISALIGN_CHECK_EN undefined, target bits [1:0] SHALL be forced to 0 and misalign_err SHALL be tied to 0.

Structure
REQ-032 Package pc_pkg SHALL hold the state enum pc_state_t (BOOT, RUN, HALT) and the default constants PC_XLEN=32, PC_STEP=4.
REQ-033 The next-PC priority mux SHALL be sub-module pc_next_sel; it is combinational, and the FSM and the PC register stay in pc_gen.

Verification
REQ-034 Reset release with fetch_ready=1 -> the bench SHALL see fetch_valid low for 1 cycle, then fetch_pc 0x0, 0x4, 0x8 on consecutive cycles.
REQ-035 fetch_ready=0 for 3 cycles at PC 0x10 -> the bench SHALL see fetch_pc held at 0x10, then 0x14 after ready.
REQ-036 redirect 0x100 and trap 0x800 in the same cycle while stall=1 -> the bench SHALL see fetch_pc=0x800 next cycle.
REQ-037 halt_req at PC 0x20, then trap 0x40, then resume -> the bench SHALL see halted=1 with fetch_valid=0, fetch_pc=0x40 while halted, then fetch resumes at 0x40.
REQ-038 PC_MISALIGN_CHECK_EN defined, redirect 0x102 -> the bench SHALL see the PC unchanged and misalign_err=1 for exactly one cycle; macro undefined -> fetch_pc=0x100.
REQ-039 XLEN=16, PC 0xFFFC, handshake -> the bench SHALL see fetch_pc=0x0000 and pc_plus=0x0004.

Source files
------------

// File: rtl/pc_pkg.sv
// ============================================================================
// Module  : pc_pkg
// Purpose : Shared types and defaults for the program-counter generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int PC_XLEN = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    function automatic logic is_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// Module  : pc_next_sel
// Purpose : Combinational next-PC priority mux (trap > redirect > hold > step).
//           Misaligned-target rejection enabled by macro PC_MISALIGN_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN = PC_XLEN,
    parameter int STEP = PC_STEP
) (
    input  pc_state_t       state,
    input  logic [XLEN-1:0] pc,
    input  logic            handshake,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            take;
    logic [XLEN-1:0] target;

    always_comb begin
        next_pc  = pc;
        misalign = 1'b0;
        take     = 1'b0;
        target   = '0;

        // Redirects are only honoured while running; traps also reach HALT.
        case (state)
            RUN: begin
                if (trap_valid) begin
                    take   = 1'b1;
                    target = trap_vector;
                end else if (redirect_valid) begin
                    take   = 1'b1;
                    target = redirect_pc;
                end else if (handshake) begin
                    next_pc = pc + XLEN'(STEP);
                end
            end
            HALT: begin
                if (trap_valid) begin
                    take   = 1'b1;
                    target = trap_vector;
                end
            end
            default: ;
        endcase

        if (take) begin
`ifdef PC_MISALIGN_CHECK_EN
            if (is_aligned(target[1:0])) begin
                next_pc = target;
            end else begin
                misalign = 1'b1;
            end
`else
            next_pc = target & ALIGN_MASK;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module  : pc_gen
// Purpose : Fetch PC generator with BOOT/RUN/HALT control and fetch handshake.
//           Optional target alignment check: macro PC_MISALIGN_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter int              STEP         = PC_STEP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            halted,
    output logic            misalign_err
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_err_q, misalign_err_d;
    logic            handshake;

    assign fetch_valid  = (state_q == RUN) && !stall;
    assign handshake    = fetch_valid && fetch_ready;
    assign fetch_pc     = pc_q;
    assign pc_plus      = pc_q + XLEN'(STEP);
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_err_q;

    pc_next_sel #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_next_sel (
        .state          (state_q),
        .pc             (pc_q),
        .handshake      (handshake),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (pc_d),
        .misalign       (misalign_err_d)
    );

    // halt_req wins over resume so a debugger can keep the core parked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (resume && !halt_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            pc_q           <= RESET_VECTOR;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module  : tb_pc_gen
// Purpose : Self-checking bench for pc_gen (directed scenarios + random run).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        fetch_ready = 1'b0;

    logic        fetch_valid, halted, misalign_err;
    logic [31:0] fetch_pc, pc_plus;
    logic        fv16, halted16, mis16;
    logic [15:0] pc16, plus16;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_booting, m_halted, m_err, m_err_next;

    always #5 clk = ~clk;

    pc_gen u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .halt_req       (halt_req),
        .resume         (resume),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .pc_plus        (pc_plus),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    pc_gen #(
        .XLEN         (16),
        .RESET_VECTOR (16'h0000),
        .STEP         (4)
    ) u_dut16 (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc[15:0]),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector[15:0]),
        .halt_req       (halt_req),
        .resume         (resume),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fv16),
        .fetch_pc       (pc16),
        .pc_plus        (plus16),
        .halted         (halted16),
        .misalign_err   (mis16)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;
        trap_vector    = '0;
        halt_req       = 1'b0;
        resume         = 1'b0;
        fetch_ready    = 1'b0;
    endtask

    // Leaves the bench at posedge+2 of the first BOOT cycle after release.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_pc      = 32'h0;
        m_booting = 1'b1;
        m_halted  = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_take(input logic [31:0] t);
`ifdef PC_MISALIGN_CHECK_EN
        if (t % 4 != 0) m_err_next = 1'b1;
        else            m_pc = t;
`else
        m_pc = t - (t % 4);
`endif
    endtask

    task automatic model_step();
        bit fires;
        m_err_next = 1'b0;
        fires = !m_booting && !m_halted && !stall && fetch_ready;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            if (trap_valid) model_take(trap_vector);
            if (resume && !halt_req) m_halted = 1'b0;
        end else begin
            if (trap_valid)          model_take(trap_vector);
            else if (redirect_valid) model_take(redirect_pc);
            else if (fires)          m_pc = m_pc + 32'd4;
            if (halt_req) m_halted = 1'b1;
        end
        m_err = m_err_next;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (fetch_pc !== 32'h0 || fetch_valid !== 1'b0 || halted !== 1'b0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: pc=%h fv=%b halted=%b mis=%b want pc=0 fv=0 halted=0 mis=0",
                     fetch_pc, fetch_valid, halted, misalign_err);
        end
        tick();
        rst_n       = 1'b1;
        fetch_ready = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_fv: got %b want 0", fetch_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 32'(i * 4)) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: fv=%b pc=%h want fv=1 pc=%h", i, fetch_valid, fetch_pc, 32'(i * 4));
            end
        end
        checks++;
        if (pc_plus !== 32'hC) begin
            errors++;
            $display("FAIL pc_plus: got %h want 0000000c", pc_plus);
        end
    endtask

    task automatic test_boot_ignore();
        apply_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        trap_valid     = 1'b1;
        trap_vector    = 32'h800;
        halt_req       = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (fetch_pc !== 32'h0 || halted !== 1'b0 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL boot_ignore: pc=%h halted=%b fv=%b want pc=0 halted=0 fv=1",
                     fetch_pc, halted, fetch_valid);
        end
    endtask

    task automatic test_ready_hold();
        apply_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fetch_pc !== 32'h10 || fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL ready_hold[%0d]: pc=%h fv=%b want pc=10 fv=1", i, fetch_pc, fetch_valid);
            end
            tick();
        end
        fetch_ready = 1'b1;
        tick();
        checks++;
        if (fetch_pc !== 32'h14) begin
            errors++;
            $display("FAIL ready_advance: got %h want 00000014", fetch_pc);
        end
    endtask

    task automatic test_trap_priority();
        apply_reset();
        tick();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        trap_valid     = 1'b1;
        trap_vector    = 32'h800;
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_fv: got %b want 0", fetch_valid);
        end
        tick();
        clear_inputs();
        checks++;
        if (fetch_pc !== 32'h800) begin
            errors++;
            $display("FAIL trap_priority: got %h want 00000800", fetch_pc);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (halted !== 1'b1 || fetch_valid !== 1'b0 || fetch_pc !== 32'h20) begin
            errors++;
            $display("FAIL halt_enter: halted=%b fv=%b pc=%h want 1 0 20", halted, fetch_valid, fetch_pc);
        end
        trap_valid  = 1'b1;
        trap_vector = 32'h40;
        tick();
        trap_valid = 1'b0;
        checks++;
        if (halted !== 1'b1 || fetch_valid !== 1'b0 || fetch_pc !== 32'h40) begin
            errors++;
            $display("FAIL halt_trap: halted=%b fv=%b pc=%h want 1 0 40", halted, fetch_valid, fetch_pc);
        end
        resume   = 1'b1;
        halt_req = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_wins: halted=%b want 1", halted);
        end
        halt_req = 1'b0;
        tick();
        resume = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 32'h40) begin
            errors++;
            $display("FAIL resume: halted=%b fv=%b pc=%h want 0 1 40", halted, fetch_valid, fetch_pc);
        end
        fetch_ready = 1'b1;
        tick();
        checks++;
        if (fetch_pc !== 32'h44) begin
            errors++;
            $display("FAIL resume_step: got %h want 00000044", fetch_pc);
        end
    endtask

    task automatic test_misalign();
        apply_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        checks++;
        if (fetch_pc !== 32'h0 || misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_reject: pc=%h mis=%b want pc=0 mis=1", fetch_pc, misalign_err);
        end
`else
        checks++;
        if (fetch_pc !== 32'h100 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_force: pc=%h mis=%b want pc=100 mis=0", fetch_pc, misalign_err);
        end
`endif
        tick();
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: mis=%b want 0", misalign_err);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch_ready    = 1'b1;
        checks++;
        if (pc16 !== 16'hFFFC || plus16 !== 16'h0000 || pc_plus !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pre: pc16=%h plus16=%h plus32=%h want fffc 0000 00000000", pc16, plus16, pc_plus);
        end
        tick();
        checks++;
        if (pc16 !== 16'h0000 || plus16 !== 16'h0004) begin
            errors++;
            $display("FAIL wrap16: pc=%h plus=%h want 0000 0004", pc16, plus16);
        end
        checks++;
        if (fetch_pc !== 32'h0 || pc_plus !== 32'h4) begin
            errors++;
            $display("FAIL wrap32: pc=%h plus=%h want 00000000 00000004", fetch_pc, pc_plus);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick();
        stall          = 1'b1;
        fetch_ready    = 1'b1;
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_pc !== 32'h0 || halted !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pc=%h halted=%b fv=%b want 0 0 0", fetch_pc, halted, fetch_valid);
        end
        clear_inputs();
        fetch_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_first: fv=%b pc=%h want 1 0", fetch_valid, fetch_pc);
        end
    endtask

    task automatic test_random();
        bit exp_fv;
        apply_reset();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            stall          = ($urandom_range(0, 3) == 0);
            fetch_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            trap_valid     = ($urandom_range(0, 19) == 0);
            halt_req       = ($urandom_range(0, 19) == 0);
            resume         = ($urandom_range(0, 2) == 0);
            redirect_pc    = $urandom;
            trap_vector    = $urandom;
            if ($urandom_range(0, 1) == 0) redirect_pc = redirect_pc & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) trap_vector = trap_vector & 32'hFFFF_FFFC;
            #1;
            exp_fv = !m_booting && !m_halted && !stall;
            checks++;
            if (fetch_valid !== exp_fv || fetch_pc !== m_pc || pc_plus !== m_pc + 32'd4 ||
                halted !== m_halted || misalign_err !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: fv=%b pc=%h plus=%h h=%b mis=%b want fv=%b pc=%h plus=%h h=%b mis=%b",
                         cyc, fetch_valid, fetch_pc, pc_plus, halted, misalign_err,
                         exp_fv, m_pc, m_pc + 32'd4, m_halted, m_err);
            end
            model_step();
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_boot_ignore();
        test_ready_hold();
        test_trap_priority();
        test_halt();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
